// File: rtl/bus_pkg.sv
// Shared definitions for the data/peripheral bus: address map, arbiter owner
// encoding and per-master request/response bundles.
package bus_pkg;

  localparam int NUM_M         = 2;
  localparam int MAX_BURST_DEF = 4;

  localparam logic [31:0] DM_BEGIN  = 32'h0000_0000;
  localparam logic [31:0] DM_END    = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BEGIN = 32'h0000_7F00;
  localparam logic [31:0] TC0_END   = 32'h0000_7F0B;
  localparam logic [31:0] TC1_BEGIN = 32'h0000_7F10;
  localparam logic [31:0] TC1_END   = 32'h0000_7F1B;
  localparam logic [31:0] PR_BEGIN  = 32'h0000_7F20;
  localparam logic [31:0] PR_END    = 32'h0000_7F23;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } mreq_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        err;
  } mrsp_t;

  // Inclusive window test.
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for the shared bus windows; also used by the
// top-level bridge.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [31:0] addr,
  output logic        hit_dm,
  output logic        hit_tc0,
  output logic        hit_tc1,
  output logic        hit_pr,
  output logic        mapped
);

  assign hit_dm  = in_win(addr, DM_BEGIN,  DM_END);
  assign hit_tc0 = in_win(addr, TC0_BEGIN, TC0_END);
  assign hit_tc1 = in_win(addr, TC1_BEGIN, TC1_END);
  assign hit_pr  = in_win(addr, PR_BEGIN,  PR_END);
  assign mapped  = hit_dm | hit_tc0 | hit_tc1 | hit_pr;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded bursts, registered
// acknowledge/read data and unmapped-address error reporting.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  owner
);

  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

  mreq_t [NUM_M-1:0] mreq;
  mrsp_t [NUM_M-1:0] rsp;
  logic  [NUM_M-1:0] req, gnt;

  owner_e        state, state_d;
  logic          last, last_d;
  logic          k;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;

  mreq_t      sel;
  logic       xfer;
  logic       dec_mapped, mapped;
  logic [3:0] hit;

  assign req     = {m1_req, m0_req};
  assign mreq[0] = '{addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};
  assign mreq[1] = '{addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen};

  // Grant depends on registered owner and live req only, never on address.
  assign gnt[0] = (state == OWN_M0) && req[0];
  assign gnt[1] = (state == OWN_M1) && req[1];
  assign xfer   = |gnt;

  always_comb begin
    sel = '0;
    case (state)
      OWN_M0:  sel = mreq[0];
      OWN_M1:  sel = mreq[1];
      default: sel = '0;
    endcase
  end

  bus_addr_decode u_dec (
    .addr    (sel.addr),
    .hit_dm  (hit[0]),
    .hit_tc0 (hit[1]),
    .hit_tc1 (hit[2]),
    .hit_pr  (hit[3]),
    .mapped  (dec_mapped)
  );

  assign mapped = dec_mapped & (|hit);

  assign bus_addr   = sel.addr;
  assign bus_wdata  = sel.wdata;
  assign bus_byteen = (xfer && mapped) ? sel.byteen : 4'h0;

  // Burst count including the transfer happening this cycle, so the owner
  // gets exactly MAX_BURST grants before yielding.
  always_comb begin
    cnt_inc = cnt;
    if (xfer && (cnt != CNT_MAX)) cnt_inc = cnt + 1'b1;
  end

  always_comb begin
    state_d = state;
    k       = (state == OWN_M1);
    case (state)
      OWN_IDLE: begin
        if (req[0] && (!req[1] || last)) state_d = OWN_M0;
        else if (req[1])                 state_d = OWN_M1;
      end
      OWN_M0, OWN_M1: begin
        if (req[k] && ((cnt_inc < CNT_MAX) || !req[!k])) state_d = state;
        else if (req[!k])                                 state_d = k ? OWN_M0 : OWN_M1;
        else                                              state_d = OWN_IDLE;
      end
      default: state_d = OWN_IDLE;
    endcase
    cnt_d  = (state_d == state) ? cnt_inc : '0;
    last_d = xfer ? gnt[1] : last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OWN_IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp <= '0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        rsp[i].ack   <= gnt[i];
        rsp[i].rdata <= (gnt[i] && mapped) ? bus_rdata : 32'h0;
        rsp[i].err   <= gnt[i] && !mapped;
      end
    end
  end

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_ack   = rsp[0].ack;
  assign m1_ack   = rsp[1].ack;
  assign m0_rdata = rsp[0].rdata;
  assign m1_rdata = rsp[1].rdata;
  assign m0_err   = rsp[0].err;
  assign m1_err   = rsp[1].err;
  assign owner    = state;

endmodule
